// File: rtl/limp_valve_sequencer.sv
// Turns the control FSM's mode code into timed actuator sequences: pulsed dosing (ADB)
// or drain-then-rinse (LIMP). Only one actuator is ever driven because each maps to a single state.
module limp_valve_sequencer #(
  parameter int DOSE_PULSES  = 3,
  parameter int PULSE_ON     = 4,
  parameter int PULSE_OFF    = 2,
  parameter int DRAIN_CYCLES = 8,
  parameter int RINSE_CYCLES = 5,
  parameter int CW           = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] cmd,
  output logic       pump_adb,
  output logic       valve_drain,
  output logic       valve_fill,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DOSE_ON  = 3'd1;
  localparam logic [2:0] S_DOSE_OFF = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_RINSE    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [1:0] CMD_NADA = 2'b00;
  localparam logic [1:0] CMD_ADB  = 2'b01;
  localparam logic [1:0] CMD_LIMP = 2'b10;
  localparam logic [1:0] CMD_BAD  = 2'b11;

  localparam logic [CW-1:0] ON_LOAD    = CW'(PULSE_ON - 1);
  localparam logic [CW-1:0] OFF_LOAD   = CW'(PULSE_OFF - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(DOSE_PULSES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] RINSE_LOAD = CW'(RINSE_CYCLES - 1);

  logic [2:0]    state_reg, state_next;
  logic [1:0]    active_reg, active_next;
  logic [1:0]    last_reg, last_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] pc_reg, pc_next;
  logic          aborting;

  // Any change of the sampled code while busy (including NADA or invalid) abandons the sequence.
  assign aborting = (cmd != active_reg);

  always_comb begin
    state_next  = state_reg;
    active_next = active_reg;
    last_next   = last_reg;
    cnt_next    = cnt_reg;
    pc_next     = pc_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd == CMD_ADB && last_reg != CMD_ADB) begin
          state_next  = S_DOSE_ON;
          cnt_next    = ON_LOAD;
          pc_next     = PULSE_LOAD;
          active_next = CMD_ADB;
        end else if (cmd == CMD_LIMP && last_reg != CMD_LIMP) begin
          state_next  = S_DRAIN;
          cnt_next    = DRAIN_LOAD;
          active_next = CMD_LIMP;
        end else if (cmd == CMD_NADA) begin
          last_next = CMD_NADA;
        end
      end
      S_DOSE_ON: begin
        if (aborting) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          pc_next    = '0;
        end else if (cnt_reg == '0) begin
          if (pc_reg == '0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_DOSE_OFF;
            cnt_next   = OFF_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_DOSE_OFF: begin
        if (aborting) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          pc_next    = '0;
        end else if (cnt_reg == '0) begin
          state_next = S_DOSE_ON;
          cnt_next   = ON_LOAD;
          pc_next    = pc_reg - 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_DRAIN: begin
        if (aborting) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = S_RINSE;
          cnt_next   = RINSE_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_RINSE: begin
        if (aborting) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        last_next  = active_reg;
        cnt_next   = '0;
        pc_next    = '0;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        pc_next    = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the entering edge already drives them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      active_reg  <= CMD_NADA;
      last_reg    <= CMD_NADA;
      cnt_reg     <= '0;
      pc_reg      <= '0;
      pump_adb    <= 1'b0;
      valve_drain <= 1'b0;
      valve_fill  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_reg   <= state_next;
      active_reg  <= active_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
      pc_reg      <= pc_next;
      pump_adb    <= (state_next == S_DOSE_ON);
      valve_drain <= (state_next == S_DRAIN);
      valve_fill  <= (state_next == S_RINSE);
      busy        <= (state_next == S_DOSE_ON) || (state_next == S_DOSE_OFF) ||
                     (state_next == S_DRAIN)   || (state_next == S_RINSE);
      done        <= (state_next == S_DONE);
      err         <= (cmd == CMD_BAD);
    end
  end

endmodule

// File: tb/tb_limp_valve_sequencer.sv
// Bench for limp_valve_sequencer: directed then random command/reset segments, checked every
// cycle against a schedule-based model that expands each started sequence into per-cycle outputs.
module tb_limp_valve_sequencer;

  localparam int DOSE_PULSES  = 3;
  localparam int PULSE_ON     = 4;
  localparam int PULSE_OFF    = 2;
  localparam int DRAIN_CYCLES = 8;
  localparam int RINSE_CYCLES = 5;
  localparam int CW           = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] cmd   = 2'b00;
  logic       pump_adb, valve_drain, valve_fill, busy, done, err;

  limp_valve_sequencer #(
    .DOSE_PULSES (DOSE_PULSES),
    .PULSE_ON    (PULSE_ON),
    .PULSE_OFF   (PULSE_OFF),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .RINSE_CYCLES(RINSE_CYCLES),
    .CW          (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd        (cmd),
    .pump_adb   (pump_adb),
    .valve_drain(valve_drain),
    .valve_fill (valve_fill),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cycle, obs, exp);
    end
  endtask

  // Model word per cycle: {busy, done, pump, drain, fill}
  logic [4:0] sched[$];
  logic [4:0] cur      = '0;
  int         m_active = 0;
  int         m_last   = 0;
  logic       m_err    = 1'b0;

  function automatic void build(input int code);
    sched.delete();
    if (code == 1) begin
      for (int p = 0; p < DOSE_PULSES; p++) begin
        for (int i = 0; i < PULSE_ON; i++) sched.push_back(5'b10100);
        if (p != DOSE_PULSES - 1)
          for (int i = 0; i < PULSE_OFF; i++) sched.push_back(5'b10000);
      end
    end else begin
      for (int i = 0; i < DRAIN_CYCLES; i++) sched.push_back(5'b10010);
      for (int i = 0; i < RINSE_CYCLES; i++) sched.push_back(5'b10001);
    end
    sched.push_back(5'b01000);
  endfunction

  function automatic void model_step(input logic rst_n, input logic [1:0] c);
    if (!rst_n) begin
      cur = '0;
      sched.delete();
      m_last = 0;
      m_err  = 1'b0;
    end else begin
      m_err = (c == 2'b11);
      if (cur[4]) begin
        if (int'(c) != m_active) begin
          cur = '0;
          sched.delete();
        end else begin
          cur = sched.pop_front();
        end
      end else if (cur[3]) begin
        cur    = '0;
        m_last = m_active;
      end else if ((c == 2'b01 || c == 2'b10) && int'(c) != m_last) begin
        m_active = int'(c);
        build(m_active);
        cur = sched.pop_front();
      end else if (c == 2'b00) begin
        m_last = 0;
      end
    end
  endfunction

  task automatic run_segment(input logic rst_n, input logic [1:0] c, input int len);
    logic [7:0] obs, exp;
    $display("segment: reset=%0b cmd=%b cycles=%0d", rst_n, c, len);
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      reset = rst_n;
      cmd   = c;
      @(posedge clock);
      model_step(rst_n, c);
      #1;
      cycle++;
      obs = {2'b00, pump_adb, valve_drain, valve_fill, busy, done, err};
      exp = {2'b00, cur[2], cur[1], cur[0], cur[4], cur[3], m_err};
      check_val("outputs", obs, exp);
      check_val("exclusive", 8'($countones({pump_adb, valve_drain, valve_fill}) <= 1), 8'd1);
    end
  endtask

  // Directed segments: {reset_n, cmd, length}
  typedef struct { logic rst_n; logic [1:0] c; int len; } seg_t;
  seg_t dir_segs[$];

  initial begin
    dir_segs = '{
      '{1'b0, 2'b00, 2},  '{1'b1, 2'b00, 3},  '{1'b1, 2'b01, 22}, '{1'b1, 2'b00, 2},
      '{1'b1, 2'b01, 6},  '{1'b1, 2'b00, 3},  '{1'b1, 2'b01, 20}, '{1'b1, 2'b00, 2},
      '{1'b1, 2'b10, 16}, '{1'b1, 2'b00, 2},  '{1'b1, 2'b10, 3},  '{1'b1, 2'b01, 20},
      '{1'b1, 2'b00, 2},  '{1'b1, 2'b11, 3},  '{1'b1, 2'b00, 2},  '{1'b1, 2'b10, 10},
      '{1'b0, 2'b10, 1},  '{1'b1, 2'b10, 16}, '{1'b1, 2'b10, 3},  '{1'b1, 2'b00, 2}
    };
    foreach (dir_segs[k]) run_segment(dir_segs[k].rst_n, dir_segs[k].c, dir_segs[k].len);

    for (int k = 0; k < 250; k++) begin
      logic [1:0] c;
      int r;
      r = $urandom_range(0, 99);
      c = (r < 30) ? 2'b01 : (r < 60) ? 2'b10 : (r < 88) ? 2'b00 : 2'b11;
      if ($urandom_range(0, 19) == 0) run_segment(1'b0, c, 1);
      run_segment(1'b1, c, $urandom_range(1, 22));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
